// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-indexed data memory.
// Handles sub-word stores by read-modify-write and extends sub-word loads.
module load_store_unit #(
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_READ,
        WRITE,
        RESP
    } state_t;

    localparam logic [1:0]  SIZE_BYTE = 2'b00;
    localparam logic [1:0]  SIZE_HALF = 2'b01;
    localparam logic [1:0]  SIZE_WORD = 2'b10;
    localparam logic [29:0] DEPTH_IDX = 30'(MEM_DEPTH);

    state_t      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;       // store data, then the merged word to write
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;
    logic        req_error;

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SIZE_BYTE: extend_load = {{24{sgn & b[7]}}, b};
            SIZE_HALF: extend_load = {{16{sgn & h[15]}}, h};
            default:   extend_load = word;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] w;
        w = old;
        if (size == SIZE_BYTE) begin
            w[{lane, 3'b000} +: 8] = wd[7:0];
        end else begin
            w[{lane[1], 4'b0000} +: 16] = wd[15:0];
        end
        merge_store = w;
    endfunction

    always_comb begin
        req_error = 1'b0;
        case (req_size)
            SIZE_HALF: req_error = req_addr[0];
            SIZE_WORD: req_error = |req_addr[1:0];
            2'b11:     req_error = 1'b1;
            default:   req_error = 1'b0;
        endcase
        if (req_addr[31:2] >= DEPTH_IDX) begin
            req_error = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    data_d   = req_wdata;
                    rdata_d  = 32'h0;
                    error_d  = req_error;
                    if (req_error) begin
                        state_d = RESP;
                    end else if (!req_write) begin
                        state_d = LOAD;
                    end else if (req_size == SIZE_WORD) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RMW_READ;
                    end
                end
            end
            LOAD: begin
                rdata_d = extend_load(mem_read_data, size_q, addr_q[1:0], signed_q);
                state_d = RESP;
            end
            RMW_READ: begin
                data_d  = merge_store(mem_read_data, data_q, size_q, addr_q[1:0]);
                state_d = WRITE;
            end
            WRITE: begin
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is sampled on the clock edge here, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= 32'h0;
            data_q   <= 32'h0;
            rdata_q  <= 32'h0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
        end
    end

    // Reset gates the strobe combinationally so a reset in WRITE never reaches memory.
    assign mem_write_enable = (state_q == WRITE) && !reset;
    assign mem_address      = {2'b00, addr_q[31:2]};
    assign mem_write_data   = data_q;
    assign req_ready        = (state_q == IDLE);
    assign resp_valid       = (state_q == RESP);
    assign resp_rdata       = rdata_q;
    assign resp_error       = error_q;

endmodule
